derivada_activacion: RTL
========================

# derivada_activacion

Sequential backward-pass companion to the piecewise-linear activation unit. It takes a pre-activation input `Entrada` and an upstream gradient `Gradiente`, finds the linear segment containing `Entrada` with a 5-step binary search over a runtime-programmable breakpoint table, and multiplies the gradient by that segment's slope. The fixed-point result goes to the training datapath between neuron layers, under valid/ready handshakes on both sides.

## Interface
- `Width`, 32, data word width (signed fixed point)
- `Magnitud`, 7, integer bits
- `Precision`, 24, fraction bits; `Signo + Magnitud + Precision == Width`
- `Signo`, 1, sign bit count

- `CLK`  in  1  single clock, rising edge
- `RESET_N`  in  1  reset, asynchronous and active-low
- `InValid` / `InReady`  in / out  1  input handshake
- `Entrada`  in  Width  signed pre-activation x
- `Gradiente`  in  Width  signed upstream gradient g
- `Enable`  in  1  sampled with the input; 0 forces a zero result
- `OutValid` / `OutReady`  out / in  1  output handshake
- `Salida`  out  Width  signed g·f'(x)
- `Error`  out  1  result saturated
- `WrEn`  in  1  table write strobe
- `WrSel`  in  1  0 = breakpoint table A, 1 = slope table M
- `WrAddr`  in  5  table index
- `WrDato`  in  Width  table write data

## Operation
- Tables: A[0..30] (ascending breakpoints) and M[1..30] (slopes). M[0] and M[31] are hardwired to 0. Writes to A[31], M[0] and M[31] are ignored.
- Writes take effect only in IDLE. A `WrEn` in any other state is dropped.
- Segment definition: seg = number of k in 0..30 with Entrada ≥ A[k], giving 0..31. The tables must be sorted ascending; if they are not, the search result is undefined but the FSM still completes.
- FSM states:
  - IDLE: `InReady`=1. On `InValid`, latch Entrada, Gradiente and Enable, set seg=0, b=4, and go to BUSCA.
  - BUSCA: 5 cycles, b=4..0. Compute cand = seg | (1<<b). If Entrada ≥ A[cand−1], set seg=cand. After b=0, go to MULT.
  - MULT: compute p = g·M[seg] as a full 2·Width signed product. Add 2^(Precision−1) (round half up), then shift right arithmetically by Precision. Saturate to the Width range: results above the range give 0x7FF…F, results below give 0x800…0, and `Error`=1 in either case. If the latched Enable=0, the result is 0 and `Error`=0. Register the result and go to SALIDA.
  - SALIDA: `OutValid`=1. `Salida` and `Error` hold stable until `OutReady`, then go to IDLE.
- Reset values: state IDLE, `InReady`=1, `OutValid`=0, `Salida`=0, `Error`=0, all table entries 0. Reset asserted mid-operation aborts the transaction, and no output is produced.

## Timing
- Acceptance happens at the edge where `InValid`&&`InReady`. `InReady` drops in the next cycle.
- `OutValid` rises exactly 7 cycles after the accepting edge (5 BUSCA + 1 MULT + register).
- With `OutReady` held high, the output is consumed on its first cycle and `InReady` is 1 the following cycle. Minimum throughput is 1 result per 8 cycles.
- No pipelining: `InReady`=0 throughout BUSCA, MULT and SALIDA.
- In IDLE, a write and an input acceptance in the same cycle are both honoured, and the search sees the new table value.

## Structure
- Shared include file holds the FSM state encodings (IDLE, BUSCA, MULT, SALIDA), the rounding constant expression and the saturation limits, so the forward unit can reuse them.
- One sub-module, `mult_punto_fijo`: a combinational signed multiply with rounding, shift and saturation, with outputs result and overflow, parameterised like the top.
- Top holds the FSM, the search counter and the two register tables.

## Test plan
Setup for all scenarios: A[k]=(k−15)<<24 (−15.0…15.0) and M[k]=k<<20 (k/16).

- Basic: x=0x00800000 (0.5), g=0x00300000 → seg 16, M=1.0. Expect `Salida`=0x00300000, `Error`=0, `OutValid` 7 cycles after acceptance.
- Boundaries:
  - x=0x00000000 (equal to A[15]) → seg 16, same result as above.
  - x=−20.0 → seg 0, `Salida`=0.
  - x=15.0 → seg 31, `Salida`=0.
- Saturation: M[16]=0x10000000, g=0x10000000, x=0.5 → 0x7FFFFFFF, `Error`=1. With g=0xF0000000 → 0x80000000, `Error`=1.
- Rounding and Enable:
  - M[16]=0x00800000, g=0x00000001 → 0x00000001.
  - Same input with `Enable`=0 → 0, `Error`=0.
- Backpressure: hold `OutReady`=0 for 10 cycles. `Salida` stays stable and `InReady`=0. A `WrEn` to M[16] issued during the wait is ignored, so the next transaction still uses the old slope.
- Reset: assert `RESET_N`=0 in the 3rd BUSCA cycle. All outputs read reset values, `OutValid` never rises, and the tables read 0 (the next x=0.5 gives `Salida`=0).

Source files
------------

// File: rtl/derivada_activacion_pkg.sv
// Shared definitions for the activation units: FSM state encodings, the
// rounding constant and the saturation limits of the fixed-point datapath.
package derivada_activacion_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSCA  = 2'd1;
    localparam logic [1:0] ST_MULT   = 2'd2;
    localparam logic [1:0] ST_SALIDA = 2'd3;

    localparam int ANCHO_MAX = 128;
    typedef logic signed [ANCHO_MAX-1:0] amplio_t;

    // Half an LSB of the result, added before the shift (round half up).
    function automatic amplio_t redondeo(input int precision);
        return amplio_t'(1) <<< (precision - 1);
    endfunction

    function automatic amplio_t limite_max(input int width);
        return (amplio_t'(1) <<< (width - 1)) - amplio_t'(1);
    endfunction

    function automatic amplio_t limite_min(input int width);
        return -(amplio_t'(1) <<< (width - 1));
    endfunction

endpackage

// File: rtl/mult_punto_fijo.sv
// Combinational signed fixed-point multiply with round-half-up, arithmetic
// shift by Precision and saturation to the Width range.
module mult_punto_fijo
    import derivada_activacion_pkg::*;
#(
    parameter int Width     = 32,
    parameter int Magnitud  = 7,
    parameter int Precision = 24,
    parameter int Signo     = 1
) (
    input  logic signed [Width-1:0] a,
    input  logic signed [Width-1:0] b,
    output logic signed [Width-1:0] result,
    output logic                    overflow
);

    localparam int PW = 2 * Width;
    localparam logic signed [PW-1:0] RED  = PW'(redondeo(Precision));
    localparam logic signed [PW-1:0] MAXV = PW'(limite_max(Width));
    localparam logic signed [PW-1:0] MINV = PW'(limite_min(Width));

    if (Signo + Magnitud + Precision != Width) begin : g_formato_invalido
        $error("mult_punto_fijo: Signo + Magnitud + Precision must equal Width");
    end

    logic signed [PW-1:0] a_ext;
    logic signed [PW-1:0] b_ext;
    logic signed [PW-1:0] producto;
    logic signed [PW-1:0] desplazado;

    assign a_ext      = $signed({{Width{a[Width-1]}}, a});
    assign b_ext      = $signed({{Width{b[Width-1]}}, b});
    assign producto   = a_ext * b_ext;
    assign desplazado = (producto + RED) >>> Precision;

    always_comb begin
        result   = $signed(desplazado[Width-1:0]);
        overflow = 1'b0;
        if (desplazado > MAXV) begin
            result   = $signed(MAXV[Width-1:0]);
            overflow = 1'b1;
        end else if (desplazado < MINV) begin
            result   = $signed(MINV[Width-1:0]);
            overflow = 1'b1;
        end
    end

endmodule

// File: rtl/derivada_activacion.sv
// Backward pass of the piecewise-linear activation: binary-searches the
// segment of Entrada in a programmable breakpoint table and scales Gradiente.
module derivada_activacion
    import derivada_activacion_pkg::*;
#(
    parameter int Width     = 32,
    parameter int Magnitud  = 7,
    parameter int Precision = 24,
    parameter int Signo     = 1
) (
    input  logic                    CLK,
    input  logic                    RESET_N,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic signed [Width-1:0] Entrada,
    input  logic signed [Width-1:0] Gradiente,
    input  logic                    Enable,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic signed [Width-1:0] Salida,
    output logic                    Error,
    input  logic                    WrEn,
    input  logic                    WrSel,
    input  logic [4:0]              WrAddr,
    input  logic [Width-1:0]        WrDato
);

    logic [1:0]              estado;
    logic                    fase_mult;
    logic [2:0]              bit_q;
    logic [4:0]              seg_q;
    logic signed [Width-1:0] x_q;
    logic signed [Width-1:0] g_q;
    logic                    en_q;
    logic signed [Width-1:0] pend_q;
    logic signed [Width-1:0] salida_q;
    logic                    error_q;

    logic signed [Width-1:0] tabla_a [0:31];
    logic signed [Width-1:0] tabla_m [0:31];

    logic [4:0]              cand;
    logic signed [Width-1:0] umbral;
    logic signed [Width-1:0] pendiente;
    logic signed [Width-1:0] mult_res;
    logic                    mult_ovf;

    assign InReady  = (estado == ST_IDLE);
    assign OutValid = (estado == ST_SALIDA);
    assign Salida   = salida_q;
    assign Error    = error_q;

    // cand is never 0 during the search, so cand-1 stays inside A[0..30].
    assign cand      = seg_q | (5'd1 << bit_q);
    assign umbral    = tabla_a[cand - 5'd1];
    assign pendiente = (seg_q == 5'd0 || seg_q == 5'd31) ? '0 : tabla_m[seg_q];

    mult_punto_fijo #(
        .Width    (Width),
        .Magnitud (Magnitud),
        .Precision(Precision),
        .Signo    (Signo)
    ) u_mult (
        .a       (g_q),
        .b       (pend_q),
        .result  (mult_res),
        .overflow(mult_ovf)
    );

    // NOTE: the tables are flop arrays, not RAM, so they take the async reset;
    // a reset must leave every breakpoint and slope at 0.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int k = 0; k < 32; k++) begin
                tabla_a[k] <= '0;
                tabla_m[k] <= '0;
            end
        end else if (WrEn && estado == ST_IDLE && WrAddr != 5'd31) begin
            if (!WrSel) begin
                tabla_a[WrAddr] <= $signed(WrDato);
            end else if (WrAddr != 5'd0) begin
                tabla_m[WrAddr] <= $signed(WrDato);
            end
        end
    end

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // blocking ones would let later statements see same-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            estado    <= ST_IDLE;
            fase_mult <= 1'b0;
            bit_q     <= '0;
            seg_q     <= '0;
            x_q       <= '0;
            g_q       <= '0;
            en_q      <= 1'b0;
            pend_q    <= '0;
            salida_q  <= '0;
            error_q   <= 1'b0;
        end else begin
            case (estado)
                ST_IDLE: begin
                    if (InValid) begin
                        x_q    <= Entrada;
                        g_q    <= Gradiente;
                        en_q   <= Enable;
                        seg_q  <= '0;
                        bit_q  <= 3'd4;
                        estado <= ST_BUSCA;
                    end
                end
                ST_BUSCA: begin
                    if (x_q >= umbral) begin
                        seg_q <= cand;
                    end
                    if (bit_q == 3'd0) begin
                        fase_mult <= 1'b0;
                        estado    <= ST_MULT;
                    end else begin
                        bit_q <= bit_q - 3'd1;
                    end
                end
                ST_MULT: begin
                    // First cycle registers the slope read, second registers the product.
                    if (!fase_mult) begin
                        pend_q    <= pendiente;
                        fase_mult <= 1'b1;
                    end else begin
                        salida_q <= en_q ? mult_res : '0;
                        error_q  <= en_q & mult_ovf;
                        estado   <= ST_SALIDA;
                    end
                end
                ST_SALIDA: begin
                    if (OutReady) begin
                        estado <= ST_IDLE;
                    end
                end
                default: estado <= ST_IDLE;
            endcase
        end
    end

endmodule
